// File: rtl/data_mem_responder.sv
// Data-side memory responder: byte-lane RAM plus an MMIO console FIFO with sticky overflow.
// Optional 64-bit cycle counter at 0x80000008/0x8000000C when DATA_MEM_CYCLE_COUNTER_EN is defined.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [3:0]  dwe,
  input  logic [31:0] wrdata,
  output logic [31:0] drdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = FW + 1;

  localparam logic [1:0] REG_CON_DATA   = 2'd0;
  localparam logic [1:0] REG_CON_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE_LO   = 2'd2;
  localparam logic [1:0] REG_CYCLE_HI   = 2'd3;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifoMem [FIFO_DEPTH];

  logic [FW-1:0] wrPtr_q, wrPtr_d;
  logic [FW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] wordIdx;
  logic          isMmio;
  logic [1:0]    regSel;
  logic          ramWrite;
  logic          pushReq;
  logic          pushAccept;
  logic          pop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          statusWrite;
  logic [4:0]    statusCount;
  logic [31:0]   statusWord;

  // Address bits that play no part in decoding (RAM aliasing, byte offset).
  logic          unused_addrBits;
  assign unused_addrBits = ^{daddr[30:AW+2], daddr[1:0]};

  assign wordIdx     = daddr[AW+1:2];
  assign isMmio      = daddr[31];
  assign regSel      = daddr[3:2];
  assign ramWrite    = !isMmio && (dwe != 4'b0000);
  assign pushReq     = isMmio && (regSel == REG_CON_DATA) && dwe[0];
  assign statusWrite = isMmio && (regSel == REG_CON_STATUS) && (dwe != 4'b0000);

  assign fifoFull    = (count_q == CW'(FIFO_DEPTH));
  assign fifoEmpty   = (count_q == '0);
  assign con_valid   = !fifoEmpty;
  assign con_data    = fifoEmpty ? 8'h00 : fifoMem[rdPtr_q];
  assign pop         = con_valid && con_ready;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign pushAccept  = pushReq && (!fifoFull || pop);

  assign statusCount = 5'(count_q);
  assign statusWord  = {23'b0, statusCount, 1'b0, overflow_q, fifoEmpty, fifoFull};

`ifdef DATA_MEM_CYCLE_COUNTER_EN
  logic [63:0] cycleCnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_q + 64'd1;
    end
  end
`endif

  always_comb begin
    drdata = '0;
    if (!isMmio) begin
      drdata = mem[wordIdx];
    end else begin
      case (regSel)
        REG_CON_STATUS: drdata = statusWord;
`ifdef DATA_MEM_CYCLE_COUNTER_EN
        REG_CYCLE_LO:   drdata = cycleCnt_q[31:0];
        REG_CYCLE_HI:   drdata = cycleCnt_q[63:32];
`endif
        default:        drdata = '0;
      endcase
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pushAccept) begin
      wrPtr_d = wrPtr_q + FW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + FW'(1);
    end
    if (pushAccept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !pushAccept) begin
      count_d = count_q - CW'(1);
    end
    if (pushReq && fifoFull && !pop) begin
      overflow_d = 1'b1;
    end else if (statusWrite) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays carry no reset; FIFO validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (ramWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) begin
          mem[wordIdx][8*i +: 8] <= wrdata[8*i +: 8];
        end
      end
    end
    if (pushAccept) begin
      fifoMem[wrPtr_q] <= wrdata[7:0];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: RAM lanes/aliasing, console FIFO, reset, counter.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [3:0]  dwe;
  logic [31:0] wrdata;
  logic [31:0] drdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  int errors;
  int checks;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwe      (dwe),
    .wrdata   (wrdata),
    .drdata   (drdata),
    .con_valid(con_valid),
    .con_data (con_data),
    .con_ready(con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    daddr  = addr;
    dwe    = we;
    wrdata = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Single-cycle write followed by returning the bus to idle.
  task automatic writeWord(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    applyStimulus(addr, we, data);
    tick();
    applyStimulus(addr, 4'b0000, 32'h0);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(addr, 4'b0000, 32'h0);
    #1;
    checkOutput(tag, drdata, expected);
  endtask

  logic [31:0] cntA;
  logic [31:0] cntB;

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    con_ready = 1'b0;
    applyStimulus(32'h0, 4'b0000, 32'h0);
    #1;
    checkOutput("reset_con_valid", {31'b0, con_valid}, 32'h0);
    checkOutput("reset_con_data", {24'b0, con_data}, 32'h0);
    #20;
    reset = 1'b1;
    readCheck("status_after_reset", 32'h8000_0004, 32'h0000_0002);

    $display("[TB] RAM byte lanes and aliasing");
    writeWord(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    readCheck("ram_full_word", 32'h0000_0010, 32'hDEAD_BEEF);
    writeWord(32'h0000_0010, 4'b0010, 32'h0000_5500);
    readCheck("ram_lane1_merge", 32'h0000_0010, 32'hDEAD_55EF);
    writeWord(32'h0000_0010, 4'b1000, 32'hAB00_0000);
    readCheck("ram_lane3_merge", 32'h0000_0013, 32'hABAD_55EF);
    writeWord(32'h0000_0004, 4'b1111, 32'h1234_5678);
    readCheck("ram_alias", 32'h0000_1004, 32'h1234_5678);
    readCheck("ram_neighbour_kept", 32'h0000_0010, 32'hABAD_55EF);

    $display("[TB] MMIO decode");
    readCheck("con_data_reads_zero", 32'h8000_0000, 32'h0);
    writeWord(32'h8000_0000, 4'b0010, 32'h0000_0077);
    readCheck("no_push_without_lane0", 32'h8000_0004, 32'h0000_0002);
    writeWord(32'h8000_0008, 4'b1111, 32'hFFFF_FFFF);
    readCheck("unmapped_write_ignored", 32'h8000_0004, 32'h0000_0002);

    $display("[TB] FIFO overflow and drain");
    for (int i = 0; i < 9; i++) begin
      writeWord(32'h8000_0000, 4'b0001, 32'h41 + i);
    end
    readCheck("status_full_ovf", 32'h8000_0004, 32'h0000_0085);
    checkOutput("head_after_fill", {24'b0, con_data}, 32'h41);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_valid", {31'b0, con_valid}, 32'h1);
      checkOutput("drain_byte", {24'b0, con_data}, 32'h41 + i);
      tick();
    end
    checkOutput("drained_valid", {31'b0, con_valid}, 32'h0);
    checkOutput("drained_data", {24'b0, con_data}, 32'h0);
    readCheck("status_empty_ovf_sticky", 32'h8000_0004, 32'h0000_0006);
    writeWord(32'h8000_0004, 4'b0100, 32'h0);
    readCheck("status_ovf_cleared", 32'h8000_0004, 32'h0000_0002);

    $display("[TB] push into full FIFO with concurrent pop");
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      writeWord(32'h8000_0000, 4'b0001, 32'h50 + i);
    end
    readCheck("status_full", 32'h8000_0004, 32'h0000_0081);
    con_ready = 1'b1;
    writeWord(32'h8000_0000, 4'b0001, 32'h0000_005A);
    con_ready = 1'b0;
    readCheck("status_full_no_ovf", 32'h8000_0004, 32'h0000_0081);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("pushpop_byte", {24'b0, con_data}, (i == 7) ? 32'h5A : (32'h51 + i));
      tick();
    end
    checkOutput("pushpop_empty", {31'b0, con_valid}, 32'h0);

    $display("[TB] mid-operation reset");
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      writeWord(32'h8000_0000, 4'b0001, 32'h60 + i);
    end
    checkOutput("pre_reset_valid", {31'b0, con_valid}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'b0, con_valid}, 32'h0);
    checkOutput("async_reset_data", {24'b0, con_data}, 32'h0);
    #2;
    reset = 1'b1;
    tick();
    readCheck("status_after_midreset", 32'h8000_0004, 32'h0000_0002);

    $display("[TB] cycle counter");
    applyStimulus(32'h8000_0008, 4'b0000, 32'h0);
    #1;
    cntA = drdata;
    repeat (5) tick();
    cntB = drdata;
`ifdef DATA_MEM_CYCLE_COUNTER_EN
    checkOutput("counter_delta", cntB - cntA, 32'd5);
    readCheck("counter_hi", 32'h8000_000C, 32'h0);
`else
    checkOutput("counter_lo_a", cntA, 32'h0);
    checkOutput("counter_lo_b", cntB, 32'h0);
    readCheck("counter_hi_unmapped", 32'h8000_000C, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
